// File: rtl/two_of_five_scanner.sv
// ---------------------------------------------------------------------------
// two_of_five_scanner
//
// Front end of the 2-out-of-5 display matrix decoder. Accepts 2-out-of-5
// coded digits over a valid/ready handshake into a one-entry pending buffer,
// and swaps the pending code into the displayed slot only at a frame
// boundary so a digit never tears mid-scan. Rows 1..7 are scanned at a rate
// of one row per SCAN_DIV clocks; the row index goes out on ch1..ch3 together
// with the column pattern of the displayed code.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     in_code is valid this cycle
//   in_code      2-out-of-5 code, bit weights b4..b0 = 7,4,2,1,0
//   in_ready     pending buffer empty (combinational)
//   ch1..ch3     row select MSB..LSB, 000 blanks the matrix
//   cols         column drive, equal to the displayed code
//   digit        decoded displayed digit, 4'hF when none or invalid
//   err          displayed code does not have exactly two ones
//   frame_start  one-cycle pulse on the first row-1 cycle after a 7->1 wrap
// ---------------------------------------------------------------------------
module two_of_five_scanner #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:0] in_code,
  output logic       in_ready,
  output logic       ch1,
  output logic       ch2,
  output logic       ch3,
  output logic [4:0] cols,
  output logic [3:0] digit,
  output logic       err,
  output logic       frame_start
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

  // Number of ones in a 5-bit code.
  function automatic logic [2:0] count_ones(input logic [4:0] code);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, code[i]};
    end
    return n;
  endfunction

  // Digit value of a code; every popcount-2 code maps to exactly one digit.
  function automatic logic [3:0] decode_digit(input logic [4:0] code);
    logic [3:0] d;
    case (code)
      5'b11000: d = 4'd0;
      5'b00011: d = 4'd1;
      5'b00101: d = 4'd2;
      5'b00110: d = 4'd3;
      5'b01001: d = 4'd4;
      5'b01010: d = 4'd5;
      5'b01100: d = 4'd6;
      5'b10001: d = 4'd7;
      5'b10010: d = 4'd8;
      5'b10100: d = 4'd9;
      default:  d = 4'hF;
    endcase
    return d;
  endfunction

  // Architectural state
  logic [15:0] presc_q, presc_d;
  logic [2:0]  row_q, row_d;
  logic [4:0]  pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic [4:0]  disp_q, disp_d;
  logic        disp_loaded_q, disp_loaded_d;

  // Registered outputs
  logic [2:0]  ch_q, ch_d;
  logic [4:0]  cols_q, cols_d;
  logic [3:0]  digit_q, digit_d;
  logic        err_q, err_d;
  logic        frame_start_q, frame_start_d;

  logic        tick_s;
  logic        wrap_s;
  logic        accept_s;
  logic        disp_valid_s;

  assign in_ready = !pend_full_q && !rst;

  // Prescaler, row counter, buffers, and the output image of the next state.
  always_comb begin
    tick_s   = (presc_q == PRESC_MAX);
    wrap_s   = tick_s && (row_q == 3'd7);
    accept_s = in_valid && in_ready;

    if (tick_s) begin
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end

    if (tick_s) begin
      if (row_q == 3'd7) begin
        row_d = 3'd1;
      end else begin
        row_d = row_q + 3'd1;
      end
    end else begin
      row_d = row_q;
    end

    // A transfer needs an empty pending buffer, so it can never coincide
    // with a swap that empties it; the two branches are exclusive.
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    disp_d        = disp_q;
    disp_loaded_d = disp_loaded_q;
    if (wrap_s && pend_full_q) begin
      disp_d        = pend_q;
      disp_loaded_d = 1'b1;
      pend_full_d   = 1'b0;
    end else if (accept_s) begin
      pend_d      = in_code;
      pend_full_d = 1'b1;
    end else begin
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
    end

    // Outputs are derived from the next state so that the registers show
    // the state that holds after the edge.
    disp_valid_s = (count_ones(disp_d) == 3'd2);
    if (disp_loaded_d && disp_valid_s) begin
      ch_d    = row_d;
      cols_d  = disp_d;
      digit_d = decode_digit(disp_d);
      err_d   = 1'b0;
    end else if (disp_loaded_d) begin
      ch_d    = 3'd0;
      cols_d  = 5'd0;
      digit_d = 4'hF;
      err_d   = 1'b1;
    end else begin
      ch_d    = 3'd0;
      cols_d  = 5'd0;
      digit_d = 4'hF;
      err_d   = 1'b0;
    end

    frame_start_d = wrap_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= 16'd0;
      row_q         <= 3'd1;
      pend_q        <= 5'd0;
      pend_full_q   <= 1'b0;
      disp_q        <= 5'd0;
      disp_loaded_q <= 1'b0;
      ch_q          <= 3'd0;
      cols_q        <= 5'd0;
      digit_q       <= 4'hF;
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      row_q         <= row_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      disp_q        <= disp_d;
      disp_loaded_q <= disp_loaded_d;
      ch_q          <= ch_d;
      cols_q        <= cols_d;
      digit_q       <= digit_d;
      err_q         <= err_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign {ch1, ch2, ch3} = ch_q;
  assign cols            = cols_q;
  assign digit           = digit_q;
  assign err             = err_q;
  assign frame_start     = frame_start_q;

endmodule

// File: tb/tb_two_of_five_scanner.sv
// ---------------------------------------------------------------------------
// Bench for two_of_five_scanner. Two instances (SCAN_DIV=4 and SCAN_DIV=1)
// share the stimulus. A model based on elapsed cycles since reset computes
// the row from plain arithmetic, holds the pending code as a one-entry slot
// and the displayed code separately; every cycle both instances are checked
// against it, and a set of literal expectations pins the model itself.
// ---------------------------------------------------------------------------
module tb_two_of_five_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_code;

  logic       a_rdy, a_ch1, a_ch2, a_ch3, a_err, a_fs;
  logic [4:0] a_cols;
  logic [3:0] a_digit;
  logic       b_rdy, b_ch1, b_ch2, b_ch3, b_err, b_fs;
  logic [4:0] b_cols;
  logic [3:0] b_digit;

  two_of_five_scanner #(.SCAN_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .in_ready(a_rdy), .ch1(a_ch1), .ch2(a_ch2), .ch3(a_ch3),
    .cols(a_cols), .digit(a_digit), .err(a_err), .frame_start(a_fs)
  );

  two_of_five_scanner #(.SCAN_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .in_ready(b_rdy), .ch1(b_ch1), .ch2(b_ch2), .ch3(b_ch3),
    .cols(b_cols), .digit(b_digit), .err(b_err), .frame_start(b_fs)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state per instance
  int         m_t  [2];
  bit         m_pv [2];
  logic [4:0] m_pc [2];
  bit         m_ld [2];
  logic [4:0] m_dc [2];
  bit         m_fs [2];

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Packed view: {ch[2:0], cols[4:0], digit[3:0], err, frame_start, in_ready}
  function automatic logic [14:0] pk(input logic [2:0] c, input logic [4:0] co,
                                     input logic [3:0] d, input logic e,
                                     input logic f, input logic r);
    return {c, co, d, e, f, r};
  endfunction

  function automatic logic [14:0] dut_out(input int i);
    if (i == 0) return {a_ch1, a_ch2, a_ch3, a_cols, a_digit, a_err, a_fs, a_rdy};
    return {b_ch1, b_ch2, b_ch3, b_cols, b_digit, b_err, b_fs, b_rdy};
  endfunction

  function automatic logic [3:0] lookup(input logic [4:0] code);
    logic [4:0] tbl [10];
    tbl = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
            5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};
    for (int k = 0; k < 10; k++) begin
      if (tbl[k] == code) return 4'(k);
    end
    return 4'hF;
  endfunction

  function automatic logic [14:0] model_out(input int i);
    int         row;
    bit         act;
    logic [2:0] c;
    row = (m_t[i] % (7 * div_of(i))) / div_of(i) + 1;
    c   = 3'(row);
    act = m_ld[i] && ($countones(m_dc[i]) == 2);
    if (act)
      return pk(c, m_dc[i], lookup(m_dc[i]), 1'b0, m_fs[i], !rst && !m_pv[i]);
    return pk(3'd0, 5'd0, 4'hF, m_ld[i], m_fs[i], !rst && !m_pv[i]);
  endfunction

  // Advance the model across the edge just taken, then compare every output.
  task automatic step();
    logic [14:0] got, want;
    bit wrap, acc;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_t[i] = 0; m_pv[i] = 1'b0; m_pc[i] = 5'd0;
        m_ld[i] = 1'b0; m_dc[i] = 5'd0; m_fs[i] = 1'b0;
      end else begin
        wrap = ((m_t[i] + 1) % (7 * div_of(i))) == 0;
        acc  = in_valid && !m_pv[i];
        if (wrap && m_pv[i]) begin
          m_dc[i] = m_pc[i]; m_ld[i] = 1'b1; m_pv[i] = 1'b0;
        end
        if (acc) begin
          m_pc[i] = in_code; m_pv[i] = 1'b1;
        end
        m_fs[i] = wrap;
        m_t[i]  = m_t[i] + 1;
      end
      got  = dut_out(i);
      want = model_out(i);
      n_vec++;
      if (got !== want) begin
        n_miss++;
        $display("FAIL cycle_check inst%0d t=%0d: got %b want %b ({ch,cols,digit,err,fs,rdy})",
                 i, m_t[i], got, want);
      end
    end
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic chk(input string name, input int i, input logic [14:0] exp);
    logic [14:0] got;
    got = dut_out(i);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s dut inst%0d: got %b want %b", name, i, got, exp);
    end
    got = model_out(i);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s model inst%0d: got %b want %b", name, i, got, exp);
    end
  endtask

  task automatic wait_t(input int target);
    int k;
    k = 0;
    while (m_t[0] != target && k < 1000) begin
      step();
      k++;
    end
    if (m_t[0] != target) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_t timeout: got t=%0d want t=%0d", m_t[0], target);
    end
  endtask

  task automatic offer(input logic [4:0] code);
    in_valid = 1'b1;
    in_code  = code;
    step();
    in_valid = 1'b0;
    in_code  = 5'd0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = 5'd0;
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_pv[i] = 1'b0; m_pc[i] = 5'd0;
      m_ld[i] = 1'b0; m_dc[i] = 5'd0; m_fs[i] = 1'b0;
    end

    // Reset held for three edges, then released
    repeat (3) step();
    chk("reset_held", 0, pk(3'd0, 5'd0, 4'hF, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    #1;
    chk("reset_release", 0, pk(3'd0, 5'd0, 4'hF, 1'b0, 1'b0, 1'b1));

    // Load code 5 at cycle 5; shown after the wrap at cycle 28
    wait_t(5);
    offer(5'b01010);
    chk("ready_drop", 0, pk(3'd0, 5'd0, 4'hF, 1'b0, 1'b0, 1'b0));
    step();
    chk("div1_wrap", 1, pk(3'd1, 5'b01010, 4'd5, 1'b0, 1'b1, 1'b1));
    step();
    chk("div1_row2", 1, pk(3'd2, 5'b01010, 4'd5, 1'b0, 1'b0, 1'b1));
    wait_t(27);
    chk("blank_before_wrap", 0, pk(3'd0, 5'd0, 4'hF, 1'b0, 1'b0, 1'b0));
    step();
    chk("first_frame", 0, pk(3'd1, 5'b01010, 4'd5, 1'b0, 1'b1, 1'b1));

    // Scan rows with code 5 displayed
    wait_t(32);
    chk("row2", 0, pk(3'd2, 5'b01010, 4'd5, 1'b0, 1'b0, 1'b1));
    wait_t(55);
    chk("row7", 0, pk(3'd7, 5'b01010, 4'd5, 1'b0, 1'b0, 1'b1));
    step();
    chk("second_frame", 0, pk(3'd1, 5'b01010, 4'd5, 1'b0, 1'b1, 1'b1));

    // Invalid code blanks with err, then a valid code recovers
    step();
    offer(5'b11100);
    wait_t(84);
    chk("invalid_shown", 0, pk(3'd0, 5'd0, 4'hF, 1'b1, 1'b1, 1'b1));
    step();
    offer(5'b10100);
    wait_t(112);
    chk("recover_9", 0, pk(3'd1, 5'b10100, 4'd9, 1'b0, 1'b1, 1'b1));

    // Back-pressure: 00110 held while the pending slot is full
    step();
    offer(5'b10001);
    in_valid = 1'b1;
    in_code  = 5'b00110;
    wait_t(139);
    chk("bp_blocked", 0, pk(3'd7, 5'b10100, 4'd9, 1'b0, 1'b0, 1'b0));
    step();
    chk("bp_swap", 0, pk(3'd1, 5'b10001, 4'd7, 1'b0, 1'b1, 1'b1));
    step();
    in_valid = 1'b0;
    in_code  = 5'd0;
    chk("bp_taken", 0, pk(3'd1, 5'b10001, 4'd7, 1'b0, 1'b0, 1'b0));
    wait_t(168);
    chk("bp_shown_3", 0, pk(3'd1, 5'b00110, 4'd3, 1'b0, 1'b1, 1'b1));

    // Reset mid-frame with code 7 displayed and 00110 pending
    offer(5'b10001);
    wait_t(197);
    offer(5'b00110);
    wait_t(208);
    chk("pre_reset_row4", 0, pk(3'd4, 5'b10001, 4'd7, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    step();
    step();
    chk("mid_reset", 0, pk(3'd0, 5'd0, 4'hF, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    wait_t(28);
    chk("after_reset_wrap", 0, pk(3'd0, 5'd0, 4'hF, 1'b0, 1'b1, 1'b1));
    wait_t(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/two_of_five_scanner.md
Name: two_of_five_scanner

Overview:
- Upstream stage of the 2-out-of-5 display matrix decoder.
- Accepts 2-out-of-5 coded digits over a valid/ready handshake and validates them.
- Drives the matrix decoder's 3-bit row select ch1..ch3, scanning rows 1..7 at a divided rate, together with the 5-bit column pattern.
- New codes are double-buffered and swapped only at frame boundaries, so a digit never tears mid-scan.

Parameters:
- SCAN_DIV, 4: clock cycles per row; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  5  2-out-of-5 code, bit weights b4..b0 = 7,4,2,1,0.
- in_ready  output  1  pending buffer empty; a transfer occurs when in_valid & in_ready.
- ch1  output  1  row select MSB.
- ch2  output  1  row select.
- ch3  output  1  row select LSB; {ch1,ch2,ch3}=0 blanks the matrix.
- cols  output  5  column drive, active-high, equal to the displayed code.
- digit  output  4  decoded digit 0..9 of the displayed code; 4'hF when none or invalid.
- err  output  1  the displayed code does not have exactly two ones.
- frame_start  output  1  one-cycle pulse when the row scan wraps from 7 to 1.

Behaviour:
- Code table, digit:b4..b0
  - 0:11000, 1:00011, 2:00101, 3:00110, 4:01001
  - 5:01010, 6:01100, 7:10001, 8:10010, 9:10100
- Any code with a popcount other than 2 is invalid.
- Outputs
  - All outputs except in_ready are registered.
  - in_ready = !pend_full & !rst.
- Reset, while rst is high at an edge:
  - prescaler=0, row=1, pend_full=0, disp_loaded=0, disp_code=0.
  - ch=000, cols=0, digit=F, err=0, frame_start=0.
  - Reset applied mid-frame discards both pending and displayed codes.
  - rst overrides every simultaneous event.
- Prescaler
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted when prescaler==SCAN_DIV-1.
  - With SCAN_DIV=1, tick is asserted every cycle.
- Row counter
  - On tick: row increments, and 7 wraps to 1 (frame end).
  - Each row lasts exactly SCAN_DIV cycles. A frame is 7*SCAN_DIV cycles.
  - Row 1 starts on the first cycle after reset release.
- Input handshake
  - On in_valid & in_ready: pend<=in_code and pend_full<=1.
  - in_ready drops on the following cycle.
  - in_code is not checked on input; invalid codes are accepted.
- Frame swap, on tick with row==7:
  - If pend_full: disp_code<=pend, disp_loaded<=1, pend_full<=0.
  - Otherwise the displayed code is unchanged.
  - No input transfer can coincide with the swap, because in_ready=0 while pend_full.
  - in_ready returns to 1 on the cycle after the swap.
- Visible state, active = disp_loaded & valid(disp_code):
  - If active: {ch1,ch2,ch3}=row, cols=disp_code, digit=decoded value, err=0.
  - If disp_loaded & !valid: ch=000, cols=0, digit=F, err=1.
  - If !disp_loaded: ch=000, cols=0, digit=F, err=0.
  - The row counter and prescaler run in every case.
- Output registers reflect the state after each edge. The ch value for row r is present for the r-th SCAN_DIV-cycle window.
- frame_start is high for exactly one cycle, the cycle in which row==1 after the 7→1 wrap. It pulses even when the display is blanked.

Test Plan:
1. Reset: hold rst 3 cycles, release -> ch=000, cols=0, digit=F, err=0, frame_start=0, in_ready=1; row 1 lasts 4 cycles.
2. Load: offer in_code=01010 at cycle 5 -> in_ready=0 from cycle 6; outputs stay blank until the 7→1 wrap (cycle 28 after release); then frame_start pulses, ch=001, cols=01010, digit=5, err=0.
3. Scan: with code 5 displayed -> ch steps 001..111, each held 4 cycles, then wraps to 001; period 28; frame_start pulses once per period.
4. Invalid: load 11100 -> after the next wrap ch=000, cols=0, digit=F, err=1; then load 10100 -> after the following wrap err=0, digit=9, scanning resumes.
5. Back-pressure: hold in_valid with 00110 while pend_full -> no transfer; accepted on the cycle after the swap; shown one frame later, digit=3.
6. Reset mid-frame: pend_full=1 and code 7 displayed; rst high at row 4 -> all outputs return to reset values; the pending code never appears.
